// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO definitions for the station-management master and the PHY-side receptor.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PREAMBLE,
    S_FRAME,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [5:0] FRAME_LEN = 6'd32;
  localparam logic [5:0] TA_IDX    = 6'd14;
  localparam logic [5:0] DATA_IDX  = 6'd16;

  // Field positions within the 32-bit frame word
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: HALF_PERIOD cycles low then HALF_PERIOD high, with strobes marking the edge about to happen.
// Latency: MDC starts low in the first enabled cycle; strobes are combinational.
// Backpressure: none; held low and reset whenever en is low.
module mdio_clk_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic mdc,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RESET || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobes flag the clock edge at which MDC is about to toggle
  assign rise_evt = en && !mdc && (cnt == CNT_MAX);
  assign fall_evt = en &&  mdc && (cnt == CNT_MAX);

endmodule

// File: rtl/mdio_controller.sv
// Clause-22 MDIO master: optional preamble then a 32-bit frame, read data captured MSB first.
// Latency: MDIO_DONE at 2 + (PRE_LEN+32)*2*HALF_PERIOD cycles after start accept, 2 on reject.
// Backpressure: MDIO_START is only sampled in IDLE; requests while BUSY are dropped.
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int PRE_LEN     = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        MDIO_DONE,
  output logic        ERR,
  output logic        BUSY
);

  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);

  state_t      state, state_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [5:0]  next_k;
  logic [31:0] sh, sh_nxt;
  logic [15:0] rd_shift, rd_shift_nxt, rd_data_nxt;
  logic [1:0]  op;
  logic        is_read, is_read_nxt;
  logic        out_nxt, oe_nxt, rdy_nxt, done_nxt, err_nxt;
  logic        clk_en, fall_evt, rise_evt;

  assign clk_en = (state == S_PREAMBLE) || (state == S_FRAME);
  assign BUSY   = (state != S_IDLE);
  assign op     = sh[OP_MSB:OP_LSB];
  assign next_k = bit_cnt + 6'd1;

  mdio_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (clk_en),
    .mdc      (MDC),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      rd_shift  <= '0;
      is_read   <= 1'b0;
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      RD_DATA   <= '0;
      DATA_RDY  <= 1'b0;
      MDIO_DONE <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sh        <= sh_nxt;
      rd_shift  <= rd_shift_nxt;
      is_read   <= is_read_nxt;
      MDIO_OUT  <= out_nxt;
      MDIO_OE   <= oe_nxt;
      RD_DATA   <= rd_data_nxt;
      DATA_RDY  <= rdy_nxt;
      MDIO_DONE <= done_nxt;
      ERR       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    sh_nxt       = sh;
    rd_shift_nxt = rd_shift;
    is_read_nxt  = is_read;
    out_nxt      = MDIO_OUT;
    oe_nxt       = MDIO_OE;
    rd_data_nxt  = RD_DATA;
    rdy_nxt      = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        out_nxt = 1'b0;
        oe_nxt  = 1'b0;
        if (MDIO_START) begin
          sh_nxt    = T_DATA;
          state_nxt = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((op == OP_WRITE) || (op == OP_READ)) begin
          is_read_nxt = (op == OP_READ);
          bit_cnt_nxt = '0;
          oe_nxt      = 1'b1;
          if (PRE_LEN > 0) begin
            state_nxt = S_PREAMBLE;
            out_nxt   = 1'b1;
          end else begin
            state_nxt = S_FRAME;
            out_nxt   = sh[31];
          end
        end else begin
          err_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
      end

      S_PREAMBLE: begin
        if (fall_evt) begin
          if (bit_cnt == PRE_LAST) begin
            state_nxt   = S_FRAME;
            bit_cnt_nxt = '0;
            out_nxt     = sh[31];
          end else begin
            bit_cnt_nxt = next_k;
            out_nxt     = 1'b1;
          end
        end
      end

      S_FRAME: begin
        if (rise_evt && is_read && (bit_cnt >= DATA_IDX)) begin
          rd_shift_nxt = {rd_shift[14:0], MDIO_IN};
        end
        // The frame shifts on the falling event so MDIO_OUT moves with MDC going low
        if (fall_evt) begin
          if (bit_cnt == FRAME_LEN - 6'd1) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            rdy_nxt   = is_read;
            out_nxt   = 1'b0;
            oe_nxt    = 1'b0;
            if (is_read) begin
              rd_data_nxt = rd_shift;
            end
          end else begin
            bit_cnt_nxt = next_k;
            sh_nxt      = {sh[30:0], 1'b0};
            out_nxt     = sh[30];
            oe_nxt      = !(is_read && (next_k >= TA_IDX));
          end
        end
      end

      S_DONE: begin
        out_nxt   = 1'b0;
        oe_nxt    = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: a cycle-level waveform model of two instances (default and fast
// parameters) checked every cycle, plus literal latency/data expectations per transaction.
module tb_mdio_controller;

  logic        clk;
  logic        rst     [2];
  logic        start   [2];
  logic [31:0] tdata   [2];
  logic        mdio_in [2];
  logic        mdc     [2];
  logic        mout    [2];
  logic        moe     [2];
  logic [15:0] rd_data [2];
  logic        rdy     [2];
  logic        done    [2];
  logic        err     [2];
  logic        busy    [2];

  int n_chk;
  int n_bad;
  int cyc;
  bit chk_en;

  // Model state
  bit          active   [2];
  int          d        [2];
  logic [31:0] tx       [2];
  logic [15:0] rd_exp   [2];
  logic [15:0] phy_word [2];

  mdio_controller #(.HALF_PERIOD(2), .PRE_LEN(32)) dut (
    .CLK(clk), .RESET(rst[0]), .MDIO_START(start[0]), .T_DATA(tdata[0]), .MDIO_IN(mdio_in[0]),
    .MDC(mdc[0]), .MDIO_OUT(mout[0]), .MDIO_OE(moe[0]), .RD_DATA(rd_data[0]),
    .DATA_RDY(rdy[0]), .MDIO_DONE(done[0]), .ERR(err[0]), .BUSY(busy[0])
  );

  mdio_controller #(.HALF_PERIOD(1), .PRE_LEN(0)) dut_fast (
    .CLK(clk), .RESET(rst[1]), .MDIO_START(start[1]), .T_DATA(tdata[1]), .MDIO_IN(mdio_in[1]),
    .MDC(mdc[1]), .MDIO_OUT(mout[1]), .MDIO_OE(moe[1]), .RD_DATA(rd_data[1]),
    .DATA_RDY(rdy[1]), .MDIO_DONE(done[1]), .ERR(err[1]), .BUSY(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int plen(input int i);
    return (i == 0) ? 32 : 0;
  endfunction

  function automatic int hp(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit op_ok(input logic [31:0] w);
    return (w[29:28] == 2'b01) || (w[29:28] == 2'b10);
  endfunction

  function automatic bit op_rd(input logic [31:0] w);
    return w[29:28] == 2'b10;
  endfunction

  function automatic int end_t(input int i, input logic [31:0] w);
    return op_ok(w) ? 2 + (plen(i) + 32) * 2 * hp(i) : 2;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model update: acceptance, cycle position within a transaction, reset abort
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst[i]) begin
        active[i] = 1'b0;
        rd_exp[i] = 16'h0000;
      end else if (active[i]) begin
        d[i]++;
        if (d[i] == end_t(i, tx[i]) && op_ok(tx[i]) && op_rd(tx[i])) rd_exp[i] = phy_word[i];
        if (d[i] > end_t(i, tx[i])) active[i] = 1'b0;
      end else if (start[i]) begin
        active[i] = 1'b1;
        d[i]      = 1;
        tx[i]     = tdata[i];
      end
    end
  end

  // Per-cycle compare against the model, then PHY-side MDIO_IN for the cycle
  always @(negedge clk) begin : cmp
    logic e_mdc, e_out, e_oe, e_rdy, e_done, e_err, e_busy, use_out;
    int   b, ph, k;
    for (int i = 0; i < 2; i++) begin
      e_mdc = 0; e_out = 0; e_oe = 0; e_rdy = 0; e_done = 0; e_err = 0; e_busy = 0;
      use_out = 1; k = -1;
      if (active[i]) begin
        e_busy = 1;
        if (d[i] == end_t(i, tx[i])) begin
          e_done = 1;
          e_err  = !op_ok(tx[i]);
          e_rdy  = op_ok(tx[i]) && op_rd(tx[i]);
        end else if (d[i] >= 2 && op_ok(tx[i])) begin
          b     = (d[i] - 2) / (2 * hp(i));
          ph    = (d[i] - 2) % (2 * hp(i));
          e_mdc = (ph >= hp(i));
          e_oe  = 1;
          if (b < plen(i)) begin
            e_out = 1;
          end else begin
            k = b - plen(i);
            if (op_rd(tx[i]) && k >= 14) begin
              e_oe    = 0;
              use_out = 0;
            end else begin
              e_out = tx[i][31-k];
            end
          end
        end
      end
      if (chk_en) begin
        chk($sformatf("mdc%0d", i),  mdc[i],  e_mdc);
        chk($sformatf("oe%0d", i),   moe[i],  e_oe);
        if (use_out) chk($sformatf("out%0d", i), mout[i], e_out);
        chk($sformatf("rdy%0d", i),  rdy[i],  e_rdy);
        chk($sformatf("done%0d", i), done[i], e_done);
        chk($sformatf("err%0d", i),  err[i],  e_err);
        chk($sformatf("busy%0d", i), busy[i], e_busy);
        chk($sformatf("rd%0d", i),   rd_data[i], rd_exp[i]);
      end
      mdio_in[i] = (k >= 16) ? phy_word[i][31-k] : 1'b1;
    end
  end

  task automatic issue(input int i, input logic [31:0] w, output int t0);
    @(negedge clk);
    start[i] = 1'b1;
    tdata[i] = w;
    t0 = cyc;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk($sformatf("done_seen%0d", i), (at >= 0) ? 1 : 0, 1);
  endtask

  initial begin : stim
    int t0, at, at2, target;
    n_chk = 0; n_bad = 0; cyc = 0; chk_en = 0;
    active = '{0, 0}; d = '{0, 0};
    rst = '{0, 0}; start = '{0, 0};
    tdata = '{32'h0, 32'h0};
    phy_word = '{16'h1234, 16'hC3A5};
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", busy[0], 0);
    chk("rst_mdc", mdc[0], 0);
    chk("rst_rd", rd_data[0], 16'h0000);
    rst = '{1, 1};

    // Write with defaults
    issue(0, 32'h508ABEEF, t0);
    wait_done(0, 400, at);
    chk("wr_latency", at - t0, 258);
    chk("wr_rdy", rdy[0], 0);
    chk("wr_rd", rd_data[0], 16'h0000);

    // Read returning 0x1234
    issue(0, 32'h60880000, t0);
    wait_done(0, 400, at);
    chk("rd_latency", at - t0, 258);
    chk("rd_rdy", rdy[0], 1);
    chk("rd_value", rd_data[0], 16'h1234);

    // Rejected opcode
    issue(0, 32'h708A0000, t0);
    wait_done(0, 10, at);
    chk("rej_latency", at - t0, 2);
    chk("rej_err", err[0], 1);
    chk("rej_rd_kept", rd_data[0], 16'h1234);

    // START held through a write; frame word changed mid-frame must not matter
    @(negedge clk);
    start[0] = 1'b1;
    tdata[0] = 32'h508ABEEF;
    t0 = cyc;
    repeat (40) @(negedge clk);
    tdata[0] = 32'h708A0000;
    wait_done(0, 400, at);
    chk("held_latency", at - t0, 258);
    wait_done(0, 10, at2);
    chk("reaccept_gap", at2 - at, 3);
    chk("reaccept_err", err[0], 1);
    start[0] = 1'b0;

    // Reset asserted at frame bit 20 of a read
    phy_word[0] = 16'hBEEF;
    issue(0, 32'h60880000, t0);
    target = t0 + 2 + (32 + 20) * 4;
    while (cyc < target) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_oe", moe[0], 0);
    chk("abort_rd", rd_data[0], 16'h0000);
    rst[0] = 1'b1;

    issue(0, 32'h5A3C9E01, t0);
    wait_done(0, 400, at);
    chk("post_rst_latency", at - t0, 258);

    // Fast instance: no preamble, one-cycle half period
    issue(1, 32'h508ABEEF, t0);
    wait_done(1, 200, at);
    chk("fast_wr_latency", at - t0, 66);
    issue(1, 32'h60880000, t0);
    wait_done(1, 200, at);
    chk("fast_rd_latency", at - t0, 66);
    chk("fast_rd_value", rd_data[1], 16'hC3A5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
